// File: rtl/serial_add_pkg.sv
// Shared types and constants for the serial adder controller.
// Holds the FSM encoding, slice width and counter sizing helper.
package serial_add_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  localparam int SLICE_W = 2;

  // Step counter width: clog2(WIDTH/2), at least one bit.
  function automatic int cnt_w(input int width);
    int steps;
    steps = width / SLICE_W;
    return (steps <= 1) ? 1 : $clog2(steps);
  endfunction

endpackage

// File: rtl/fa2_slice.sv
// Combinational 2-bit ripple full adder slice.
// c_msb is the carry into bit 1 (for signed overflow).
module fa2_slice (
  input  logic [1:0] a,
  input  logic [1:0] b,
  input  logic       ci,
  output logic [1:0] s,
  output logic       co,
  output logic       c_msb
);

  assign s[0]  = a[0] ^ b[0] ^ ci;
  assign c_msb = (a[0] & b[0]) | (ci & (a[0] ^ b[0]));
  assign s[1]  = a[1] ^ b[1] ^ c_msb;
  assign co    = (a[1] & b[1]) | (c_msb & (a[1] ^ b[1]));

endmodule

// File: rtl/serial_add_ctrl.sv
// Multi-cycle adder: 2 bits per clock through one fa2_slice.
// Define SERIAL_ADD_CTRL_OVF_EN to add the signed-overflow port OVF.
module serial_add_ctrl
  import serial_add_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             IN_VALID,
  output logic             IN_READY,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             CIN,
  output logic             OUT_VALID,
  input  logic             OUT_READY,
  output logic [WIDTH-1:0] SUM,
  output logic             COUT,
`ifdef SERIAL_ADD_CTRL_OVF_EN
  output logic             OVF,
`endif
  output logic             BUSY
);

  localparam int STEPS = WIDTH / SLICE_W;
  localparam int CW    = cnt_w(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(STEPS - 1);

  if ((WIDTH < 2) || ((WIDTH % 2) != 0)) begin : g_bad_width
    $error("serial_add_ctrl: WIDTH must be even and >= 2");
  end

  state_e           r_state;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic             r_c;
  logic [CW-1:0]    r_cnt;
  logic [WIDTH-1:0] r_sum;
  logic             r_cout;
  logic             r_in_ready;
  logic             r_out_valid;
  logic             r_busy;

  logic [1:0]       w_s;
  logic             w_co;
  logic             w_c_msb;
  logic [WIDTH-1:0] w_sum_nxt;

  fa2_slice u_slice (
    .a     (r_a[1:0]),
    .b     (r_b[1:0]),
    .ci    (r_c),
    .s     (w_s),
    .co    (w_co),
    .c_msb (w_c_msb)
  );

  // New slice bits enter the sum register from the top.
  if (WIDTH == SLICE_W) begin : g_sum_w2
    assign w_sum_nxt = w_s;
  end else begin : g_sum_wide
    assign w_sum_nxt = {w_s, r_sum[WIDTH-1:SLICE_W]};
  end

`ifdef SERIAL_ADD_CTRL_OVF_EN
  logic r_ovf;

  // Overflow latched on the final step, held until next result.
  always_ff @(posedge CLK) begin
    if (RST) begin
      r_ovf <= 1'b0;
    end else if (r_state == RUN && r_cnt == LAST) begin
      r_ovf <= w_c_msb ^ w_co;
    end
  end

  assign OVF = r_ovf;
`else
  logic w_unused_cmsb;
  assign w_unused_cmsb = w_c_msb;
`endif

  // Controller FSM with datapath and registered handshake outputs.
  always_ff @(posedge CLK) begin
    if (RST) begin
      r_state     <= IDLE;
      r_a         <= '0;
      r_b         <= '0;
      r_c         <= 1'b0;
      r_cnt       <= '0;
      r_sum       <= '0;
      r_cout      <= 1'b0;
      r_in_ready  <= 1'b1;
      r_out_valid <= 1'b0;
      r_busy      <= 1'b0;
    end else begin
      unique case (r_state)
        IDLE: begin
          if (IN_VALID) begin
            r_a        <= A;
            r_b        <= B;
            r_c        <= CIN;
            r_cnt      <= '0;
            r_state    <= RUN;
            r_in_ready <= 1'b0;
            r_busy     <= 1'b1;
          end
        end
        RUN: begin
          r_a   <= r_a >> SLICE_W;
          r_b   <= r_b >> SLICE_W;
          r_c   <= w_co;
          r_sum <= w_sum_nxt;
          r_cnt <= r_cnt + 1'b1;
          if (r_cnt == LAST) begin
            r_cout      <= w_co;
            r_state     <= DONE;
            r_out_valid <= 1'b1;
          end
        end
        DONE: begin
          if (OUT_READY) begin
            r_state     <= IDLE;
            r_out_valid <= 1'b0;
            r_busy      <= 1'b0;
            r_in_ready  <= 1'b1;
          end
        end
        default: begin
          r_state     <= IDLE;
          r_out_valid <= 1'b0;
          r_busy      <= 1'b0;
          r_in_ready  <= 1'b1;
        end
      endcase
    end
  end

  assign IN_READY  = r_in_ready;
  assign OUT_VALID = r_out_valid;
  assign BUSY      = r_busy;
  assign SUM       = r_sum;
  assign COUT      = r_cout;

endmodule
